// File: rtl/heat_timer_bank.sv
// heat_timer_bank: three independent prescaled level-handshake timers (PLA/ABS/TPU) for the heating FSM.
// Define HEAT_TIMER_REMAIN_EN to add the `remain` output (count of highest-priority running channel).
module heat_timer_bank #(
    parameter int PRESCALE = 4,
    parameter int TIME_PLA = 8,
    parameter int TIME_ABS = 10,
    parameter int TIME_TPU = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en_pla,
    input  logic en_abs,
    input  logic en_tpu,
    input  logic hold,
    output logic t_pla,
    output logic t_abs,
    output logic t_tpu,
    output logic busy
`ifdef HEAT_TIMER_REMAIN_EN
    ,
    output logic [CNT_W-1:0] remain
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    function automatic logic [CNT_W-1:0] load_val(input int t);
        return (t == 0) ? CNT_W'(1) : CNT_W'(t);
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic [2:0]    en, done, run;

    assign en   = {en_tpu, en_abs, en_pla};
    assign tick = (pre_q == PW'(PRESCALE - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end

    for (genvar g = 0; g < 3; g++) begin : ch
        localparam logic [CNT_W-1:0] LOAD = load_val(g == 0 ? TIME_PLA : g == 1 ? TIME_ABS : TIME_TPU);
        state_t           st_q;
        logic [CNT_W-1:0] cnt_q;
        logic             en_q;
        // A dropped enable wins over a same-edge completion, so an abort never flashes done.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q  <= IDLE;
                cnt_q <= '0;
                en_q  <= 1'b0;
            end else begin
                en_q <= en[g];
                case (st_q)
                    IDLE: if (en[g] && !en_q) begin
                        st_q  <= RUN;
                        cnt_q <= LOAD;
                    end
                    RUN: if (!en[g]) st_q <= IDLE;
                    else if (tick && !hold) begin
                        if (cnt_q == CNT_W'(1)) st_q <= DONE;
                        else                    cnt_q <= cnt_q - 1'b1;
                    end
                    DONE: if (!en[g]) st_q <= IDLE;
                    default: st_q <= IDLE;
                endcase
            end
        end
        assign done[g] = (st_q == DONE);
        assign run[g]  = (st_q == RUN);
    end

    assign {t_tpu, t_abs, t_pla} = done;
    assign busy = |run;

`ifdef HEAT_TIMER_REMAIN_EN
    always_comb remain = run[0] ? ch[0].cnt_q : run[1] ? ch[1].cnt_q : run[2] ? ch[2].cnt_q : '0;
`endif
endmodule

// File: tb/tb_heat_timer_bank.sv
// tb_heat_timer_bank: directed scenarios plus randomized run against a tick-counting reference model,
// using one instance with PRESCALE=1 and one with PRESCALE=4.
module tb_heat_timer_bank;
    logic clk = 1'b0;
    logic reset, en_pla, en_abs, en_tpu, hold;
    logic [2:0] t1, t4;
    logic b1, b4;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    heat_timer_bank #(.PRESCALE(1), .TIME_PLA(8), .TIME_ABS(10), .TIME_TPU(8), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .en_pla(en_pla), .en_abs(en_abs), .en_tpu(en_tpu), .hold(hold),
        .t_pla(t1[0]), .t_abs(t1[1]), .t_tpu(t1[2]), .busy(b1));

    heat_timer_bank #(.PRESCALE(4), .TIME_PLA(8), .TIME_ABS(10), .TIME_TPU(8), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .en_pla(en_pla), .en_abs(en_abs), .en_tpu(en_tpu), .hold(hold),
        .t_pla(t4[0]), .t_abs(t4[1]), .t_tpu(t4[2]), .busy(b4));

    typedef struct {
        logic [2:0] en;
        logic       hold;
        logic [2:0] t;
        logic       busy;
    } vec_t;
    vec_t tbl[16];

    // reference model: per channel a mode (0 idle, 1 counting, 2 elapsed) and ticks still needed
    int PS[2] = '{1, 4};
    int TM[3] = '{8, 10, 8};
    int mode[2][3];
    int left[2][3];
    bit pen[2][3];
    int k;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
                mode[d][c] = 0;
                left[d][c] = 0;
                pen[d][c] = 1'b0;
            end
        k = 0;
    endfunction

    function automatic void model_step(input logic [2:0] e, input logic h);
        for (int d = 0; d < 2; d++) begin
            bit tk = (k % PS[d]) == PS[d] - 1;
            for (int c = 0; c < 3; c++) begin
                if (mode[d][c] == 0) begin
                    if (e[c] && !pen[d][c]) begin
                        mode[d][c] = 1;
                        left[d][c] = TM[c];
                    end
                end else if (!e[c]) mode[d][c] = 0;
                else if (mode[d][c] == 1 && tk && !h) begin
                    left[d][c]--;
                    if (left[d][c] == 0) mode[d][c] = 2;
                end
                pen[d][c] = e[c];
            end
        end
        k++;
    endfunction

    function automatic logic [3:0] model_out(input int d);
        logic [3:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            r[c] = (mode[d][c] == 2);
            r[3] = r[3] | (mode[d][c] == 1);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] e, input logic h);
        {en_tpu, en_abs, en_pla} = e;
        hold = h;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {en_tpu, en_abs, en_pla} = 3'b000;
        hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int j;
        logic [2:0] e;
        logic h;
        for (int i = 0; i < 16; i++) begin
            tbl[i].en   = {2'b00, i >= 5};
            tbl[i].hold = 1'b0;
            tbl[i].t    = {2'b00, i >= 13};
            tbl[i].busy = (i >= 5 && i <= 12);
        end

        reset = 1'b1;
        {en_tpu, en_abs, en_pla} = 3'b000;
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_t1", {29'd0, t1}, 0);
        chk("reset_busy1", {31'd0, b1}, 0);
        chk("reset_t4", {29'd0, t4}, 0);
        reset = 1'b0;

        // single PLA request, rise sampled at edge 5
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].hold);
            chk($sformatf("p1_t_e%0d", i), {29'd0, t1}, {29'd0, tbl[i].t});
            chk($sformatf("p1_busy_e%0d", i), {31'd0, b1}, {31'd0, tbl[i].busy});
        end

        // ABS with three ticks lost to hold, then enable drop
        do_reset();
        for (int i = 0; i < 22; i++) begin
            drive({1'b0, i < 20, 1'b0}, i >= 3 && i <= 5);
            chk($sformatf("p2_tabs_e%0d", i), {31'd0, t1[1]}, {31'd0, (i >= 13 && i < 20)});
        end

        // TPU abort after 4 cycles, then fresh request
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive({(i < 4 || i >= 6), 2'b00}, 1'b0);
            chk($sformatf("p3_ttpu_e%0d", i), {31'd0, t1[2]}, {31'd0, i >= 14});
            chk($sformatf("p3_busy_e%0d", i), {31'd0, b1}, {31'd0, (i < 4 || (i >= 6 && i < 14))});
        end

        // all three channels together
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(3'b111, 1'b0);
            chk($sformatf("p4_t_e%0d", i), {29'd0, t1}, {29'd0, i >= 8, i >= 10, i >= 8});
            chk($sformatf("p4_busy_e%0d", i), {31'd0, b1}, {31'd0, i < 10});
        end

        // PRESCALE=4 latency at each prescaler phase
        for (int p = 0; p < 4; p++) begin
            int first;
            do_reset();
            for (int i = 0; i < p; i++) drive(3'b000, 1'b0);
            drive(3'b001, 1'b0);
            j = 0;
            while (!t4[0] && j < 40) begin
                drive(3'b001, 1'b0);
                j++;
            end
            first = ((3 - p) == 0) ? 4 : (3 - p);
            chk($sformatf("p5_delay_ph%0d", p), j, first + 28);
            chk($sformatf("p5_range_ph%0d", p), {31'd0, (j >= 29 && j <= 32)}, 1);
        end

        // reset while ABS is mid-count with enable held
        do_reset();
        for (int i = 0; i < 7; i++) drive(3'b010, 1'b0);
        chk("p6_busy_before", {31'd0, b1}, 1);
        reset = 1'b1;
        #1;
        chk("p6_tabs_in_reset", {31'd0, t1[1]}, 0);
        chk("p6_busy_in_reset", {31'd0, b1}, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(3'b010, 1'b0);
            chk($sformatf("p6_tabs_e%0d", i), {31'd0, t1[1]}, {31'd0, i >= 10});
        end

        // randomized run against the reference model
        do_reset();
        model_reset();
        e = 3'b000;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 7) == 0) e[c] = ~e[c];
            h = ($urandom_range(0, 3) == 0);
            drive(e, h);
            model_step(e, h);
            chk($sformatf("rnd1_c%0d", i), {28'd0, b1, t1}, {28'd0, model_out(0)});
            chk($sformatf("rnd4_c%0d", i), {28'd0, b4, t4}, {28'd0, model_out(1)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/heat_timer_bank.md
Name: heat_timer_bank

Overview:
Synthesizable responder for the pre-print heating FSM's timer handshake. It replaces the behavioural delay timers. Three independent channels (PLA, ABS, TPU) each receive a level enable from the bed/hotend FSM, count a parameterized number of prescaled ticks, and return a level done flag that stays high until the enable drops. It sits between the bed/hotend FSM's EN/EN0/EN1 outputs and its T1/T2/T3 inputs.

Parameters:
PRESCALE, 4, clk cycles per timer tick; legal range 1..65535.
TIME_PLA, 8, ticks for PLA channel (maps to T1).
TIME_ABS, 10, ticks for ABS channel (maps to T2).
TIME_TPU, 8, ticks for TPU channel (maps to T3).
CNT_W, 8, channel counter width; each TIME_x must be < 2^CNT_W.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset; clock clk
en_pla  in  1  PLA heat-timer request (level)
en_abs  in  1  ABS heat-timer request (level)
en_tpu  in  1  TPU heat-timer request (level)
hold  in  1  pause: freezes all channel counters while high
t_pla  out  1  PLA time elapsed (level)
t_abs  out  1  ABS time elapsed (level)
t_tpu  out  1  TPU time elapsed (level)
busy  out  1  at least one channel in RUN

Behaviour:
- Reset (async): prescaler=0; all channels IDLE with cnt=0; enable-history regs en_q=0; t_*=0; busy=0.
- Prescaler: free-running from reset and never affected by hold or enables. pre counts 0..PRESCALE-1 and wraps. tick=(pre==PRESCALE-1). PRESCALE=1 gives tick=1 every cycle.
- Per-channel FSM, states IDLE, RUN, DONE. Channels are identical and fully independent; any combination may run at once.
- Start is detected on a rising edge: en & ~en_q, with en_q registered each cycle.
  - IDLE -> RUN on the clock edge where the rise is sampled; load cnt=TIME_x.
  - TIME_x=0 is clamped to 1.
- RUN, on an edge with tick & ~hold:
  - if cnt==1, go to DONE;
  - else cnt <= cnt-1.
- RUN, on an edge with en sampled 0: go to IDLE (abort). t_x is never asserted. Abort takes priority over a same-edge DONE transition.
- DONE: t_x=1 (decoded from state register, no extra latency). Hold has no effect. Stays in DONE while en=1. Goes to IDLE on the edge where en is sampled 0; t_x drops after that edge.
- IDLE with en held high and no rising edge: stays IDLE. A new request requires en to go low then high.
- Latency, PRESCALE=1, hold=0: en rise sampled at edge E0 -> t_x high after edge E0+TIME_x.
- Latency, general PRESCALE: first done edge falls between E0+(TIME_x-1)*PRESCALE+1 and E0+TIME_x*PRESCALE, depending on prescaler phase.
- Hold: each tick coinciding with hold=1 is lost (not deferred). The prescaler phase is unaffected.
- Reset mid-operation: all channels return to IDLE immediately and t_*=0. Because en_q resets to 0, an enable still high at reset release starts a fresh count on the first clock edge after release.
- busy is combinational OR of (state==RUN) over channels.

Optional Feature:
Macro HEAT_TIMER_REMAIN_EN.
- Defined: adds output port remain [CNT_W-1:0], equal to the cnt of the highest-priority channel in RUN (priority PLA > ABS > TPU). remain is 0 when no channel is in RUN. remain is registered-state derived, so there is no extra latency.
- Undefined: port and logic are absent; behaviour otherwise identical.

Test Plan:
1. PRESCALE=1, TIME_PLA=8: reset, raise en_pla sampled at edge 5 -> t_pla=0 through edge 12, t_pla=1 after edge 13; busy=1 after edges 5..12, busy=0 after edge 13.
2. PRESCALE=1, TIME_ABS=10: raise en_abs at edge 0; hold=1 for edges 3..5 -> t_abs rises after edge 13 (three ticks lost); drop en_abs at edge 20 -> t_abs=0 after edge 20.
3. PRESCALE=1: raise en_tpu, drop it after 4 cycles (abort) -> t_tpu never asserts; raise again -> fresh 8-tick count, t_tpu high 8 edges after the second rise.
4. PRESCALE=1: raise en_pla, en_abs, en_tpu on the same edge E0 -> t_pla and t_tpu high after E0+8, t_abs after E0+10, all independent.
5. PRESCALE=4, TIME_PLA=8: raise en_pla at random prescaler phase -> t_pla rise lands within 29..32 cycles of E0; repeat for all 4 phases.
6. Assert reset while the ABS channel is mid-count (cnt=4) with en_abs held high -> t_abs=0 and busy=0 immediately. After release, count restarts from 10, so t_abs rises 10 edges after the first post-reset edge (PRESCALE=1).
